// File: rtl/approx_error_monitor.sv
// Error-statistics monitor for the 4x4 approximate multiplier: windowed ED sum/max/count.
// Optional squared-error accumulator enabled by defining APPROX_MON_SQERR_EN.
module approx_error_monitor #(
   parameter int WINDOW = 256,
   parameter int ACC_W  = 16,
   parameter int CNT_W  = $clog2(WINDOW + 1),
   parameter int SQ_W   = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   input  logic [7:0]       in_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] ed_sum,
   output logic [7:0]       ed_max,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy
`ifdef APPROX_MON_SQERR_EN
   ,
   output logic [SQ_W-1:0]  sq_sum
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCUM  = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] REPORT = 2'd3;

   logic [1:0]   state;
   logic [15:0]  cnt;
   logic         v1, v2;
   logic [7:0]   ex1, r1, ed2;
   logic         accept, last;
   logic [7:0]   ed_c;
   logic [ACC_W:0] sum_n;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == REPORT);
   assign busy      = (state == ACCUM) || (state == DRAIN);
   assign accept    = in_valid & in_ready;
   assign last      = (cnt == 16'(WINDOW - 1));

   assign ed_c  = (ex1 >= r1) ? (ex1 - r1) : (r1 - ex1);
   assign sum_n = {1'b0, ed_sum} + (ACC_W + 1)'(ed2);

`ifdef APPROX_MON_SQERR_EN
   logic [15:0]   sq_e;
   logic [SQ_W:0] sq_n;
   assign sq_e = {8'd0, ed2} * {8'd0, ed2};
   assign sq_n = {1'b0, sq_sum} + (SQ_W + 1)'(sq_e);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         ex1     <= '0;
         r1      <= '0;
         ed2     <= '0;
         ed_sum  <= '0;
         ed_max  <= '0;
         err_cnt <= '0;
`ifdef APPROX_MON_SQERR_EN
         sq_sum  <= '0;
`endif
      end else begin
         v1 <= accept;
         if (accept) begin
            ex1 <= {4'd0, in_a} * {4'd0, in_b};
            r1  <= in_result;
         end
         v2 <= v1;
         if (v1) ed2 <= ed_c;

         // The pipeline is always empty in IDLE, so the clear on start never races an update.
         if (v2) begin
            ed_sum  <= sum_n[ACC_W] ? '1 : sum_n[ACC_W-1:0];
            if (ed2 > ed_max) ed_max <= ed2;
            err_cnt <= err_cnt + CNT_W'(ed2 != 8'd0);
`ifdef APPROX_MON_SQERR_EN
            sq_sum  <= sq_n[SQ_W] ? '1 : sq_n[SQ_W-1:0];
`endif
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= ACCUM;
                  cnt     <= '0;
                  ed_sum  <= '0;
                  ed_max  <= '0;
                  err_cnt <= '0;
`ifdef APPROX_MON_SQERR_EN
                  sq_sum  <= '0;
`endif
               end
            end
            ACCUM: begin
               if (accept) begin
                  if (last) state <= DRAIN;
                  else      cnt   <= cnt + 16'd1;
               end
            end
            DRAIN: begin
               if (!v1 && !v2) state <= REPORT;
            end
            REPORT: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
